register_file: RTL and testbench



---
 rtl/register_file_pkg.sv | 12 +
 rtl/register_file_if.sv | 26 ++
 rtl/register_file_register_32.sv | 28 ++
 rtl/register_file.sv | 46 ++++
 tb/tb_register_file.sv | 128 ++++++++++++
 5 files changed

// File: rtl/register_file_pkg.sv
// Shared types and constants for the 32x32 architectural register file.
package register_file_pkg;

  localparam int REG_WIDTH  = 32;
  localparam int REG_COUNT  = 32;
  localparam int REG_ADDR_W = 5;

  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

  typedef logic [REG_WIDTH-1:0] word_t;

endpackage

// File: rtl/register_file_if.sv
// Write-back / decode-stage bus of the register file: one-hot write enable,
// write data, two read addresses and their read data.
interface register_file_if
  import register_file_pkg::*;
#(
  parameter int WIDTH = REG_WIDTH
);

  logic [REG_COUNT-1:0]  E;
  logic [WIDTH-1:0]      PW;
  logic [REG_ADDR_W-1:0] RA;
  logic [REG_ADDR_W-1:0] RB;
  logic [WIDTH-1:0]      PA;
  logic [WIDTH-1:0]      PB;

  modport master (
    output E, PW, RA, RB,
    input  PA, PB
  );

  modport slave (
    input  E, PW, RA, RB,
    output PA, PB
  );

endinterface

// File: rtl/register_file_register_32.sv
// Single load-enabled register with synchronous active-high clear.
module register_32
  import register_file_pkg::*;
#(
  parameter int WIDTH = REG_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ld,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] data_q;

  // NOTE: state is updated with <= so every flop samples pre-edge values;
  // clear is tested first so it wins over a load in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q <= '0;
    end else if (ld) begin
      data_q <= d;
    end
  end

  assign q = data_q;

endmodule

// File: rtl/register_file.sv
// 32x32 register file: R0 reads as zero, R1..R31 are register_32 instances
// loaded by the one-hot enable E. Define REGFILE_BYPASS_EN to forward PW to
// a read port whose address is being written in the same cycle.
module register_file
  import register_file_pkg::*;
#(
  parameter int WIDTH = REG_WIDTH,
  parameter int DEPTH = REG_COUNT
) (
  input  logic           clk,
  input  logic           reset,
  register_file_if.slave rf
);

  logic [WIDTH-1:0] regs [DEPTH];

  for (genvar i = 0; i < DEPTH; i++) begin : g_reg
    if (i == 0) begin : g_zero
      assign regs[i] = '0;
    end else begin : g_flop
      register_32 #(.WIDTH(WIDTH)) u_reg (
        .clk   (clk),
        .reset (reset),
        .ld    (rf.E[i]),
        .d     (rf.PW),
        .q     (regs[i])
      );
    end
  end

  // Forwarding is suppressed under reset: the write it would show is discarded.
  function automatic logic [WIDTH-1:0] read_port(input logic [REG_ADDR_W-1:0] addr);
    logic [WIDTH-1:0] data;
    data = (addr == ZERO_REG) ? '0 : regs[addr];
`ifdef REGFILE_BYPASS_EN
    if (!reset && addr != ZERO_REG && rf.E[addr]) begin
      data = rf.PW;
    end
`endif
    return data;
  endfunction

  assign rf.PA = read_port(rf.RA);
  assign rf.PB = read_port(rf.RB);

endmodule

// File: tb/tb_register_file.sv
// Directed, table-driven bench for register_file; expectations follow the
// REGFILE_BYPASS_EN setting of the build for same-cycle reads.
module tb_register_file;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  register_file_if #(.WIDTH(32)) bus ();

  register_file dut (
    .clk   (clk),
    .reset (reset),
    .rf    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [31:0] e;
    logic [31:0] pw;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [31:0] exp_pa;
    logic [31:0] exp_pb;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", name, actual, expected);
    end
  endtask

  // One edge with the given inputs, then E/reset released and read ports sampled.
  task automatic edge_then_idle();
    @(posedge clk);
    #1;
    bus.E = '0;
    reset = 1'b0;
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b0;
    bus.E    = '0;
    bus.PW   = '0;
    bus.RA   = '0;
    bus.RB   = '0;

    //          rst   E             PW            RA     RB     PA            PB
    vecs[0]  = '{1'b1, 32'h0000_0000, 32'h0000_0000, 5'd5,  5'd31, 32'h0000_0000, 32'h0000_0000};
    vecs[1]  = '{1'b0, 32'h0000_0008, 32'hDEAD_BEEF, 5'd3,  5'd4,  32'hDEAD_BEEF, 32'h0000_0000};
    vecs[2]  = '{1'b0, 32'h0000_0001, 32'hFFFF_FFFF, 5'd0,  5'd3,  32'h0000_0000, 32'hDEAD_BEEF};
    vecs[3]  = '{1'b0, 32'h0000_0080, 32'h1111_1111, 5'd7,  5'd3,  32'h1111_1111, 32'hDEAD_BEEF};
    vecs[4]  = '{1'b0, 32'h0000_0200, 32'hA5A5_A5A5, 5'd9,  5'd7,  32'hA5A5_A5A5, 32'h1111_1111};
    vecs[5]  = '{1'b1, 32'h0000_0200, 32'h1234_5678, 5'd9,  5'd3,  32'h0000_0000, 32'h0000_0000};
    vecs[6]  = '{1'b0, 32'h0000_0006, 32'h0000_00FF, 5'd1,  5'd2,  32'h0000_00FF, 32'h0000_00FF};
    vecs[7]  = '{1'b0, 32'h0000_0000, 32'hCAFE_F00D, 5'd1,  5'd31, 32'h0000_00FF, 32'h0000_0000};
    vecs[8]  = '{1'b0, 32'h8000_0000, 32'hCAFE_F00D, 5'd31, 5'd30, 32'hCAFE_F00D, 32'h0000_0000};
    vecs[9]  = '{1'b0, 32'h4000_0000, 32'h0BAD_C0DE, 5'd30, 5'd30, 32'h0BAD_C0DE, 32'h0BAD_C0DE};
    vecs[10] = '{1'b0, 32'hFFFF_FFFF, 32'h5A5A_5A5A, 5'd0,  5'd17, 32'h0000_0000, 32'h5A5A_5A5A};

    @(negedge clk);
    for (int i = 0; i < 11; i++) begin
      reset  = vecs[i].rst;
      bus.E  = vecs[i].e;
      bus.PW = vecs[i].pw;
      bus.RA = vecs[i].ra;
      bus.RB = vecs[i].rb;
      edge_then_idle();
      check($sformatf("v%0d_pa", i), bus.PA, vecs[i].exp_pa);
      check($sformatf("v%0d_pb", i), bus.PB, vecs[i].exp_pb);
    end

    // Same-cycle read/write of R7.
    @(negedge clk);
    bus.E  = 32'h0000_0080;
    bus.PW = 32'h1111_1111;
    edge_then_idle();
    @(negedge clk);
    bus.E  = 32'h0000_0080;
    bus.PW = 32'h2222_2222;
    bus.RA = 5'd7;
    bus.RB = 5'd0;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("rdw_pre_pa", bus.PA, 32'h2222_2222);
`else
    check("rdw_pre_pa", bus.PA, 32'h1111_1111);
`endif
    check("rdw_pre_pb_r0", bus.PB, 32'h0000_0000);
    edge_then_idle();
    check("rdw_post_pa", bus.PA, 32'h2222_2222);

    // Reset with a pending write: no forwarding before the edge, cleared after.
    @(negedge clk);
    reset  = 1'b1;
    bus.E  = 32'h0000_0080;
    bus.PW = 32'h3333_3333;
    bus.RB = 5'd7;
    #1;
    check("rst_pre_pa", bus.PA, 32'h2222_2222);
    check("rst_pre_pb", bus.PB, 32'h2222_2222);
    edge_then_idle();
    check("rst_post_pa", bus.PA, 32'h0000_0000);
    check("rst_post_pb", bus.PB, 32'h0000_0000);

    // First write after reset lands at the first edge with reset low.
    @(negedge clk);
    bus.E  = 32'h0000_0080;
    bus.PW = 32'h4444_4444;
    edge_then_idle();
    check("post_rst_wr_pa", bus.PA, 32'h4444_4444);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
